// File: rtl/dvp_tx.sv
// dvp_tx: DVP / OV7670-style camera-bus transmitter.
// Emits vsync/href/8-bit RGB565 data, two bytes per pixel, from internal
// colour bars, an internal x+y ramp, or an external FWFT pixel FIFO.
module dvp_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_data,
  input  logic        i_empty,
  output logic        o_rd,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_busy,
  output logic        o_underflow
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int HW        = $clog2(LINE_CLKS);
  localparam int V_MAX1    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX2    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX     = (V_MAX1 > V_MAX2) ? V_MAX1 : V_MAX2;
  localparam int VW        = $clog2(V_MAX + 1);
  localparam int BAR_W     = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST = HW'(LINE_CLKS - 1);
  localparam logic [HW-1:0] H_ACT2 = HW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_e;

  typedef enum logic [1:0] {
    SRC_BARS,
    SRC_RAMP,
    SRC_EXT
  } src_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  src_e          mode_q, mode_d;
  logic [7:0]    lo_q, lo_d;
  logic          uf_q, uf_d;

  logic [VW-1:0] v_len;
  logic          line_end;
  logic          state_end;

  logic [HW-1:0] x;
  logic [HW-1:0] bar_idx;
  logic          even;
  logic          href;
  logic          ext_slot;
  logic [15:0]   bar_pix;
  logic [15:0]   ramp_pix;
  logic [7:0]    byte_out;

  // Line periods spent in the current state.
  always_comb begin
    v_len = '0;
    case (state_q)
      S_VSYNC:  v_len = VW'(VSYNC_LINES);
      S_VBACK:  v_len = VW'(V_BACK);
      S_ACTIVE: v_len = VW'(V_ACTIVE);
      S_VFRONT: v_len = VW'(V_FRONT);
      default:  v_len = '0;
    endcase
  end

  assign line_end  = (h_cnt_q == H_LAST);
  assign state_end = line_end && (v_cnt_q == (v_len - VW'(1)));

  // State register plus all registered datapath state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= SRC_BARS;
      lo_q    <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      uf_q    <= uf_d;
    end
  end

  // Next-state: all frame-phase transitions fall on the last clock of a line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_enable)  state_d = S_VSYNC;
      S_VSYNC:  if (state_end) state_d = S_VBACK;
      S_VBACK:  if (state_end) state_d = S_ACTIVE;
      S_ACTIVE: if (state_end) state_d = S_VFRONT;
      S_VFRONT: if (state_end) state_d = i_enable ? S_VSYNC : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, frame-source latch and external-FIFO byte holding.
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (state_q != S_IDLE) begin
      h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
      if (line_end) v_cnt_d = state_end ? '0 : v_cnt_q + VW'(1);
      else          v_cnt_d = v_cnt_q;
    end

    mode_d = mode_q;
    if (state_d == S_VSYNC && state_q != S_VSYNC) begin
      case (i_mode)
        2'd1:    mode_d = SRC_RAMP;
        2'd2:    mode_d = SRC_EXT;
        default: mode_d = SRC_BARS;
      endcase
    end

    // Low byte of the popped word is held for the odd slot; starvation sends 0000.
    lo_d = lo_q;
    uf_d = uf_q;
    if (ext_slot) begin
      lo_d = i_empty ? 8'h00 : i_data[7:0];
      if (i_empty) uf_d = 1'b1;
    end
  end

  // Output decode from registered state/counters.
  always_comb begin
    x        = h_cnt_q >> 1;
    even     = ~h_cnt_q[0];
    href     = (state_q == S_ACTIVE) && (h_cnt_q < H_ACT2);
    ext_slot = href && even && (mode_q == SRC_EXT);
    bar_idx  = x / HW'(BAR_W);
    ramp_pix = 16'(x) + 16'(v_cnt_q);

    case (bar_idx)
      HW'(0):  bar_pix = 16'hFFFF;
      HW'(1):  bar_pix = 16'hFFE0;
      HW'(2):  bar_pix = 16'h07FF;
      HW'(3):  bar_pix = 16'h07E0;
      HW'(4):  bar_pix = 16'hF81F;
      HW'(5):  bar_pix = 16'hF800;
      HW'(6):  bar_pix = 16'h001F;
      default: bar_pix = 16'h0000;
    endcase

    case (mode_q)
      SRC_RAMP: byte_out = even ? ramp_pix[15:8] : ramp_pix[7:0];
      SRC_EXT:  byte_out = even ? (i_empty ? 8'h00 : i_data[15:8]) : lo_q;
      default:  byte_out = even ? bar_pix[15:8] : bar_pix[7:0];
    endcase

    o_vsync     = (state_q == S_VSYNC);
    o_href      = href;
    o_data      = href ? byte_out : 8'h00;
    o_rd        = ext_slot && !i_empty;
    o_sof       = (state_q == S_VSYNC) && (v_cnt_q == '0) && (h_cnt_q == '0);
    o_eof       = (state_q == S_VFRONT) && state_end;
    o_busy      = (state_q != S_IDLE);
    o_underflow = uf_q;
  end

endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: directed self-checking bench for dvp_tx with a small frame geometry.
module tb_dvp_tx;

  localparam int H_ACTIVE    = 8;
  localparam int V_ACTIVE    = 4;
  localparam int H_BLANK     = 4;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int LINE        = 20;
  localparam int FRAME       = 140;
  localparam int ACT0        = 40;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_enable;
  logic [1:0]  i_mode;
  logic [15:0] i_data;
  logic        i_empty;
  logic        o_rd, o_vsync, o_href, o_sof, o_eof, o_busy, o_underflow;
  logic [7:0]  o_data;

  int n_tests = 0;
  int n_fail  = 0;

  dvp_tx #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_mode(i_mode),
    .i_data(i_data), .i_empty(i_empty), .o_rd(o_rd), .o_vsync(o_vsync),
    .o_href(o_href), .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof),
    .o_busy(o_busy), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // FWFT FIFO model: head word visible while not empty, popped on o_rd.
  logic [15:0] fifo_mem [0:63];
  logic [5:0]  fifo_wr = '0;
  logic [5:0]  fifo_rd = '0;
  int          n_pushed = 0;
  assign i_empty = (fifo_rd == fifo_wr);
  assign i_data  = fifo_mem[fifo_rd];
  always @(posedge i_clk) if (o_rd) fifo_rd <= fifo_rd + 6'd1;

  // Per-cycle capture of one frame, t = 0 is the o_sof cycle, t = FRAME the next one.
  logic       c_vs [0:FRAME];
  logic       c_hr [0:FRAME];
  logic       c_sf [0:FRAME];
  logic       c_ef [0:FRAME];
  logic       c_rd [0:FRAME];
  logic       c_bz [0:FRAME];
  logic       c_uf [0:FRAME];
  logic [7:0] c_dt [0:FRAME];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fword(input int i);
    return {8'(i + 1), 8'(200 - i)};
  endfunction

  function automatic logic [15:0] bar_px(input int x);
    case (x)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(input int src, input int base, input int avail,
                                          input int x, input int y);
    int p;
    p = y * H_ACTIVE + x;
    if (src == 0) return bar_px(x);
    if (src == 1) return 16'(x + y);
    return (p < avail) ? fword(base + p) : 16'h0000;
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr] = fword(n_pushed);
      fifo_wr = fifo_wr + 6'd1;
      n_pushed++;
    end
  endtask

  task automatic capture_frame(input logic [1:0] mode_at50, input logic en_at50);
    for (int t = 0; t <= FRAME; t++) begin
      c_vs[t] = o_vsync; c_hr[t] = o_href; c_sf[t] = o_sof; c_ef[t] = o_eof;
      c_rd[t] = o_rd;    c_bz[t] = o_busy; c_uf[t] = o_underflow; c_dt[t] = o_data;
      if (t == 50) begin
        i_mode   = mode_at50;
        i_enable = en_at50;
      end
      if (t < FRAME) @(negedge i_clk);
    end
  endtask

  task automatic check_timing(input string p);
    int vs_n = 0, vs_bad = 0, hr_n = 0, hr_bad = 0, first_hr = -1;
    int sf_bad = 0, ef_bad = 0, dz_bad = 0, bz_bad = 0;
    for (int t = 0; t < FRAME; t++) begin
      bit eh;
      eh = (t >= ACT0) && (t < ACT0 + V_ACTIVE * LINE) && (((t - ACT0) % LINE) < 2 * H_ACTIVE);
      if (c_vs[t]) vs_n++;
      if (c_vs[t] != (t < LINE)) vs_bad++;
      if (c_hr[t]) begin
        hr_n++;
        if (first_hr < 0) first_hr = t;
      end
      if (c_hr[t] != eh) hr_bad++;
      if (c_sf[t] != (t == 0)) sf_bad++;
      if (c_ef[t] != (t == FRAME - 1)) ef_bad++;
      if (!c_hr[t] && c_dt[t] != 8'h00) dz_bad++;
      if (c_bz[t] != 1'b1) bz_bad++;
    end
    check({p, "_vsync_cycles"}, vs_n, 20);
    check({p, "_vsync_shape"}, vs_bad, 0);
    check({p, "_first_href"}, first_hr, ACT0);
    check({p, "_href_cycles"}, hr_n, 64);
    check({p, "_href_shape"}, hr_bad, 0);
    check({p, "_sof_pulse"}, sf_bad, 0);
    check({p, "_eof_pulse"}, ef_bad, 0);
    check({p, "_data_zero_blank"}, dz_bad, 0);
    check({p, "_busy_in_frame"}, bz_bad, 0);
  endtask

  task automatic check_bytes(input string p, input int src, input int base, input int avail);
    for (int y = 0; y < V_ACTIVE; y++) begin
      for (int k = 0; k < 2 * H_ACTIVE; k++) begin
        logic [15:0] px;
        logic [7:0]  eb;
        px = exp_pix(src, base, avail, k / 2, y);
        eb = (k % 2 == 0) ? px[15:8] : px[7:0];
        check($sformatf("%s_y%0d_b%0d", p, y, k), 32'(c_dt[ACT0 + LINE * y + k]), 32'(eb));
      end
    end
  endtask

  task automatic check_rd(input string p, input int avail);
    int n = 0, bad = 0;
    for (int t = 0; t < FRAME; t++) begin
      int rel, pidx;
      bit e;
      rel = t - ACT0;
      e   = 1'b0;
      if (t >= ACT0 && t < ACT0 + V_ACTIVE * LINE && (rel % LINE) < 2 * H_ACTIVE && (rel % 2) == 0) begin
        pidx = (rel / LINE) * H_ACTIVE + (rel % LINE) / 2;
        e    = (pidx < avail);
      end
      if (c_rd[t]) n++;
      if (c_rd[t] != e) bad++;
    end
    check({p, "_rd_count"}, n, avail);
    check({p, "_rd_align"}, bad, 0);
  endtask

  task automatic wait_sof(input string tag, input int limit);
    int n = 0;
    while (!o_sof && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, 32'(o_sof), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sof_n;
    i_rstn   = 1'b0;
    i_enable = 1'b0;
    i_mode   = 2'd0;
    repeat (3) @(negedge i_clk);
    check("rst_outputs", 32'({o_vsync, o_href, o_data, o_rd, o_sof, o_eof, o_busy, o_underflow}), 32'd0);
    i_rstn = 1'b1;
    repeat (5) @(negedge i_clk);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_vsync", 32'(o_vsync), 32'd0);

    // Start latency: enable seen at one edge, sof/vsync/busy visible right after it.
    i_enable = 1'b1;
    @(negedge i_clk);
    check("start_sof", 32'(o_sof), 32'd1);
    check("start_vsync", 32'(o_vsync), 32'd1);
    check("start_busy", 32'(o_busy), 32'd1);

    // Frame 1: bars; i_mode switches to ramp mid-frame and must not alter it.
    capture_frame(2'd1, 1'b1);
    check_timing("bars");
    check_bytes("bars", 0, 0, 0);
    check("bars_b2b_sof", 32'(c_sf[FRAME]), 32'd1);
    check("bars_no_rd", 32'(c_rd[ACT0]), 32'd0);

    // Frame 2: ramp.
    capture_frame(2'd2, 1'b1);
    check_timing("ramp");
    check_bytes("ramp", 1, 0, 0);

    // Frame 3: external FIFO with exactly one frame of words.
    push(32);
    capture_frame(2'd2, 1'b1);
    check_timing("ext32");
    check_bytes("ext32", 2, 0, 32);
    check_rd("ext32", 32);
    check("ext32_underflow", 32'(c_uf[FRAME]), 32'd0);

    // Frame 4: external FIFO runs dry after 20 pixels.
    push(20);
    capture_frame(2'd0, 1'b1);
    check_timing("ext20");
    check_bytes("ext20", 2, 32, 20);
    check_rd("ext20", 20);
    check("ext20_uf_before", 32'(c_uf[88]), 32'd0);
    check("ext20_uf_after", 32'(c_uf[89]), 32'd1);
    check("ext20_uf_end", 32'(c_uf[FRAME]), 32'd1);

    // Frame 5: bars, enable dropped during ACTIVE; frame completes then idles.
    capture_frame(2'd0, 1'b0);
    check_timing("stop");
    check_bytes("stop", 0, 0, 0);
    check("stop_busy_after_eof", 32'(c_bz[FRAME]), 32'd0);
    check("stop_no_sof", 32'(c_sf[FRAME]), 32'd0);
    check("stop_uf_sticky_frame", 32'(c_uf[0]), 32'd1);
    sof_n = 0;
    repeat (300) begin
      @(negedge i_clk);
      if (o_sof) sof_n++;
    end
    check("idle_no_sof", sof_n, 0);
    check("idle_busy_low", 32'(o_busy), 32'd0);
    check("idle_uf_sticky", 32'(o_underflow), 32'd1);

    // Asynchronous reset mid-line after a mid-frame mode change.
    i_mode   = 2'd0;
    i_enable = 1'b1;
    wait_sof("rst_frame_sof", 50);
    i_enable = 1'b0;
    repeat (45) @(negedge i_clk);
    i_mode = 2'd1;
    @(negedge i_clk);
    check("rst_pre_href", 32'(o_href), 32'd1);
    #1 i_rstn = 1'b0;
    #1 check("rst_async_outputs",
             32'({o_vsync, o_href, o_data, o_rd, o_sof, o_eof, o_busy, o_underflow}), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    sof_n = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_sof || o_busy) sof_n++;
    end
    check("rst_no_restart", sof_n, 0);

    // Restart: i_mode is still ramp, latched at this sof.
    i_enable = 1'b1;
    wait_sof("resume_sof", 50);
    capture_frame(2'd1, 1'b0);
    check_timing("resume");
    check_bytes("resume", 1, 0, 0);
    check("resume_busy_end", 32'(c_bz[FRAME]), 32'd0);
    check("resume_uf_cleared", 32'(c_uf[FRAME]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
